regfile_operand_stage: RTL and testbench
========================================

# regfile_operand_stage

Register file and operand-latch stage feeding the ALU's `A` and `B` inputs.
- Holds 32 general registers; register 0 is hardwired to zero.
- Reads two source registers on request and presents them, registered, one cycle later.
- Accepts one write-back per cycle, normally the ALU `Res` returning from downstream.

## Interface
Parameters:
- `DATA_W`, default 32: register and operand width; must match the ALU operand width.
- `ADDR_W`, default 5: register address width; depth is 2^ADDR_W = 32.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rd_en`  in  1  request an operand read this cycle.
- `rs_addr`  in  ADDR_W  source register for operand A.
- `rt_addr`  in  ADDR_W  source register for operand B.
- `A_out`  out  DATA_W  registered operand A, to ALU `A`.
- `B_out`  out  DATA_W  registered operand B, to ALU `B`.
- `rd_valid`  out  1  `A_out`/`B_out` were loaded by the previous cycle's `rd_en`.
- `we`  in  1  write enable.
- `wr_addr`  in  ADDR_W  destination register.
- `wr_data`  in  DATA_W  write-back data, typically ALU `Res`.

## Operation
- Storage: 32 × DATA_W registers.
  - `reg[0]` always reads 0.
  - Writes to address 0 are discarded.
- Reset (`rst`=1 at an edge):
  - All 32 registers are cleared to 0.
  - `A_out`=0, `B_out`=0, `rd_valid`=0.
  - Reset takes priority over `we` and `rd_en` in the same cycle; the write is lost and no read is launched.
- Write: at an edge with `we`=1, `rst`=0 and `wr_addr`≠0, `reg[wr_addr]` ← `wr_data`.
- Read, at an edge with `rd_en`=1 and `rst`=0:
  - `A_out` ← value of `rs_addr`.
  - `B_out` ← value of `rt_addr`.
  - `rd_valid` ← 1.
- Idle, at an edge with `rd_en`=0: `A_out` and `B_out` hold their values; `rd_valid` ← 0.
- `rs_addr` = `rt_addr` is legal; both outputs receive the same value.
- Either source address = 0 yields 0 on the corresponding output, independent of any write to 0.
- Same-edge write and read of the same nonzero address: the result depends on the macro (see Configuration).
- There is no back-pressure. The stage accepts a read every cycle and a write every cycle, both at once.
- Outputs are driven only by flops; there is no combinational path from inputs to outputs.

## Timing
- Read latency: 1 cycle, from `rd_en` sampled at edge N to `A_out`/`B_out`/`rd_valid` valid after edge N.
- Write latency: the data is visible to a read sampled at edge N+1 or later. Same-edge visibility depends on the macro.
- Throughput: 1 read and 1 write per cycle.
- `rd_valid` is a one-cycle pulse per `rd_en`. Back-to-back `rd_en` keeps `rd_valid` high continuously.
- Reset mid-operation:
  - A read launched in the reset cycle is cancelled, so `rd_valid`=0 in the following cycle.
  - Previously latched operands are zeroed.
- Reset values: `A_out`=0, `B_out`=0, `rd_valid`=0, all registers 0.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: a same-edge read of the address being written returns `wr_data`, i.e. write-first forwarding. This applies independently to `A_out` and `B_out`, and never applies to address 0.
- Undefined: a same-edge read returns the pre-write register contents, i.e. read-first. The new value is visible from the next read.
- All other behaviour is identical in both builds.

## Test plan
- Reset: preload r5=0x1234 and assert `rst` for one edge, then read rs=5, rt=5.
  - After reset: `A_out`=`B_out`=0 and `rd_valid`=0.
  - Read result: 0/0 with `rd_valid`=1.
- Basic: write r3=0x0000_000A, then r4=0x0000_0003, then read rs=3, rt=4.
  - Expect `A_out`=0xA, `B_out`=0x3, `rd_valid`=1 one cycle after `rd_en`.
  - `rd_valid`=0 on the next cycle once `rd_en` drops, with outputs held.
- Zero register: write r0=0xFFFF_FFFF, then read rs=0, rt=0. Expect `A_out`=`B_out`=0.
- Collision: r7=0x11; same edge: `we`=1, `wr_addr`=7, `wr_data`=0x22, `rd_en`=1, rs=7, rt=7.
  - With `REGFILE_BYPASS_EN`: outputs 0x22/0x22.
  - Without it: 0x11/0x11.
  - Either build: a following read returns 0x22.
- Reset priority: same edge `rst`=1, `we`=1 (r9=0x55), `rd_en`=1.
  - Expect `rd_valid`=0 next cycle.
  - A subsequent read of r9 returns 0.
- Streaming: 32 consecutive writes rN=N·0x0101, then 32 back-to-back reads rs=N, rt=31−N.
  - Each output matches its stored value; r0 reads 0.
  - `rd_valid` stays high for 32 cycles.

Source files
------------

// File: rtl/regfile_operand_stage.sv
// regfile_operand_stage
//   32-entry register file (r0 hardwired to zero) with a registered operand
//   latch feeding the ALU A/B inputs. One read request and one write-back are
//   accepted every cycle.
//
//   Optional build macro: REGFILE_BYPASS_EN
//     defined   - same-edge read of the register being written returns wr_data
//     undefined - same-edge read returns the pre-write contents
//
// Ports
//   clk       in   clock, all state updates on rising edge
//   rst       in   synchronous active-high reset (clears registers and outputs)
//   rd_en     in   launch an operand read this cycle
//   rs_addr   in   source register for operand A
//   rt_addr   in   source register for operand B
//   A_out     out  registered operand A
//   B_out     out  registered operand B
//   rd_valid  out  A_out/B_out loaded by the previous cycle's rd_en
//   we        in   write enable
//   wr_addr   in   destination register (writes to 0 are discarded)
//   wr_data   in   write-back data
module regfile_operand_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] A_out,
  output logic [DATA_W-1:0] B_out,
  output logic              rd_valid,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] a_next;
  logic [DATA_W-1:0] b_next;
  logic              wr_ok;

  assign wr_ok = we && (wr_addr != '0);

  // Operand selection; the r0 check makes zero reads independent of storage.
  always_comb begin
    a_next = (rs_addr == '0) ? '0 : regs[rs_addr];
    b_next = (rt_addr == '0) ? '0 : regs[rt_addr];
`ifdef REGFILE_BYPASS_EN
    // Write-first forwarding; wr_ok already excludes address 0.
    if (wr_ok && (wr_addr == rs_addr)) a_next = wr_data;
    if (wr_ok && (wr_addr == rt_addr)) b_next = wr_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs     <= '{default: '0};
      A_out    <= '0;
      B_out    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_ok) regs[wr_addr] <= wr_data;
      rd_valid <= rd_en;
      if (rd_en) begin
        A_out <= a_next;
        B_out <= b_next;
      end
    end
  end

endmodule

// File: tb/tb_regfile_operand_stage.sv
// Self-checking bench for regfile_operand_stage: directed test-plan steps
// followed by randomized traffic, checked against an array-based model.
module tb_regfile_operand_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic [31:0] A_out;
  logic [31:0] B_out;
  logic        rd_valid;
  logic        we = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [31:0] mem [32];
  logic [31:0] exp_a = '0;
  logic [31:0] exp_b = '0;
  logic        exp_v = 1'b0;

  always #5 clk = ~clk;

  regfile_operand_stage #(
    .DATA_W(32),
    .ADDR_W(5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .A_out    (A_out),
    .B_out    (B_out),
    .rd_valid (rd_valid),
    .we       (we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, compare after the edge.
  task automatic cycle(input logic r, input logic w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic re,
                       input logic [4:0] ra, input logic [4:0] rb);
    logic [31:0] va, vb;
    rst = r; we = w; wr_addr = wa; wr_data = wd;
    rd_en = re; rs_addr = ra; rt_addr = rb;
    if (r) begin
      foreach (mem[i]) mem[i] = '0;
      exp_a = '0; exp_b = '0; exp_v = 1'b0;
    end else begin
      va = (ra == 0) ? 32'h0 : mem[ra];
      vb = (rb == 0) ? 32'h0 : mem[rb];
`ifdef REGFILE_BYPASS_EN
      if (w && wa != 0 && wa == ra) va = wd;
      if (w && wa != 0 && wa == rb) vb = wd;
`endif
      if (w && wa != 0) mem[wa] = wd;
      exp_v = re;
      if (re) begin
        exp_a = va;
        exp_b = vb;
      end
    end
    @(posedge clk);
    #1;
    check("A_out", A_out, exp_a);
    check("B_out", B_out, exp_b);
    check("rd_valid", {31'b0, rd_valid}, {31'b0, exp_v});
  endtask

  initial begin
    foreach (mem[i]) mem[i] = '0;

    // Reset with r5 preloaded
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 5, 32'h1234, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check("reset_valid_const", {31'b0, rd_valid}, 32'h0);
    cycle(0, 0, 0, 0, 1, 5, 5);
    check("reset_r5_cleared", A_out, 32'h0);

    // Basic write then read, then idle hold
    cycle(0, 1, 3, 32'h0000_000A, 0, 0, 0);
    cycle(0, 1, 4, 32'h0000_0003, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 3, 4);
    check("basic_A", A_out, 32'h0000_000A);
    check("basic_B", B_out, 32'h0000_0003);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("hold_A", A_out, 32'h0000_000A);

    // Zero register
    cycle(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    check("r0_A", A_out, 32'h0);

    // Same-edge collision
    cycle(0, 1, 7, 32'h11, 0, 0, 0);
    cycle(0, 1, 7, 32'h22, 1, 7, 7);
`ifdef REGFILE_BYPASS_EN
    check("collide_A", A_out, 32'h22);
`else
    check("collide_A", A_out, 32'h11);
`endif
    cycle(0, 0, 0, 0, 1, 7, 7);
    check("after_collide_B", B_out, 32'h22);

    // Reset priority over write and read
    cycle(1, 1, 9, 32'h55, 1, 9, 9);
    cycle(0, 0, 0, 0, 1, 9, 9);
    check("rst_prio_r9", A_out, 32'h0);

    // Streaming writes and back-to-back reads
    for (int n = 0; n < 32; n++)
      cycle(0, 1, 5'(n), 32'(n) * 32'h0101, 0, 0, 0);
    for (int n = 0; n < 32; n++)
      cycle(0, 0, 0, 0, 1, 5'(n), 5'(31 - n));

    // Randomized traffic; narrow address range to provoke collisions
    for (int k = 0; k < 400; k++) begin
      logic [4:0] wa, ra, rb;
      wa = (k < 200) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      ra = (k < 200) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      rb = (k < 200) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      cycle(($urandom_range(0, 31) == 0), 1'($urandom), wa, $urandom,
            1'($urandom), ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
